// File: rtl/bridge_cmd_arbiter_if.sv
// Signal bundle between bridge_cmd_arbiter, its requesters and the UART-AXI bridge.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface bridge_cmd_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [2:0]         grant_id;
  logic               bridge_start;
  logic               bridge_busy;
  logic               bridge_done;
  logic [7:0]         bridge_error;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [7:0]         rsp_error;
  logic               timeout_err;
  logic               system_ready;
  logic [2:0]         arb_state;

  modport master (
    input  req_valid, bridge_busy, bridge_done, bridge_error,
    output req_ready, grant_id, bridge_start, rsp_valid, rsp_error,
           timeout_err, system_ready, arb_state
  );

  modport slave (
    output req_valid, bridge_busy, bridge_done, bridge_error,
    input  req_ready, grant_id, bridge_start, rsp_valid, rsp_error,
           timeout_err, system_ready, arb_state
  );
endinterface

// File: rtl/bridge_cmd_arbiter.sv
// Round-robin owner of the shared UART-AXI bridge command path: one transaction
// in flight, watchdog timeout, per-requester completion with an error code.
module bridge_cmd_arbiter #(
  parameter int         NUM_REQ        = 2,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] ERR_TIMEOUT    = 8'hE0
) (
  input logic                  clk,
  input logic                  rst_n,
  bridge_cmd_arbiter_if.master bus
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_TERM = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         NUM_REQ_W  = 4'(NUM_REQ);
  localparam logic [2:0]         LAST_REQ   = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] REQ_ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_RESP   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         grant_q;
  logic [2:0]         rr_q;
  logic [TIMER_W-1:0] timer_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               start_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [7:0]         rsp_error_q;
  logic               timeout_err_q;
  logic               sys_ready_q;

  logic [7:0]         valid_ext;
  logic [3:0]         scan_idx;
  logic [2:0]         pick_idx;
  logic               pick_found;

  assign valid_ext = 8'(bus.req_valid);

  // Scan requesters starting at rr_q and wrapping, so the last owner goes to the back of the line.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    scan_idx   = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_q} + 4'(k);
      if (scan_idx >= NUM_REQ_W) begin
        scan_idx = scan_idx - NUM_REQ_W;
      end
      if (!pick_found && valid_ext[scan_idx[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.bridge_busy && pick_found) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT:  state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (bus.bridge_done || (timer_q == TIMER_TERM)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:   state_d = bus.bridge_busy ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (!bus.bridge_busy) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // All outputs are registered; pulses are raised on the edge that enters GRANT/RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= 3'd0;
      rr_q          <= 3'd0;
      timer_q       <= '0;
      req_ready_q   <= '0;
      start_q       <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_error_q   <= 8'h00;
      timeout_err_q <= 1'b0;
      sys_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      sys_ready_q <= (state_d == ST_IDLE) && !bus.bridge_busy;
      unique case (state_q)
        ST_IDLE: begin
          if (state_d == ST_GRANT) begin
            grant_q     <= pick_idx;
            req_ready_q <= REQ_ONE << pick_idx;
            start_q     <= 1'b1;
          end
        end
        ST_GRANT: begin
          timer_q <= '0;
        end
        ST_ACTIVE: begin
          if (timer_q != TIMER_TERM) begin
            timer_q <= timer_q + TIMER_W'(1);
          end
          // A completion in the terminal cycle beats the watchdog.
          if (bus.bridge_done) begin
            rsp_error_q <= bus.bridge_error;
          end else if (timer_q == TIMER_TERM) begin
            rsp_error_q   <= ERR_TIMEOUT;
            timeout_err_q <= 1'b1;
          end
          if (state_d == ST_RESP) begin
            rsp_valid_q <= REQ_ONE << grant_q;
          end
        end
        ST_RESP: begin
          rr_q <= (grant_q == LAST_REQ) ? 3'd0 : grant_q + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.grant_id     = grant_q;
  assign bus.bridge_start = start_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.system_ready = sys_ready_q;
  assign bus.arb_state    = state_q;

endmodule

// File: tb/tb_bridge_cmd_arbiter.sv
// Self-checking bench for bridge_cmd_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared against a cycle-level reference model.
module tb_bridge_cmd_arbiter;

  localparam int         NumReq        = 3;
  localparam int         TimeoutCycles = 16;
  localparam logic [7:0] ErrTimeout    = 8'hE0;
  localparam logic [NumReq-1:0] ReqOne = {{(NumReq-1){1'b0}}, 1'b1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  bridge_cmd_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  bridge_cmd_arbiter #(
    .NUM_REQ       (NumReq),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .ERR_TIMEOUT   (ErrTimeout)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: phase numbers are the published status codes, the watchdog is
  // tracked as a count of elapsed ACTIVE cycles.
  int                mState = 0;
  int                mGrant = 0;
  int                mRr = 0;
  int                mActive = 0;
  logic [NumReq-1:0] mReqReady = '0;
  logic [NumReq-1:0] mRspValid = '0;
  logic              mStart = 1'b0;
  logic [7:0]        mRspError = 8'h00;
  logic              mTimeoutErr = 1'b0;
  logic              mSysReady = 1'b0;

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
    end
  endfunction

  task automatic modelStep();
    int                nxt;
    int                idx;
    logic              found;
    logic [NumReq-1:0] rot;
    if (!rst_n) begin
      mState = 0; mGrant = 0; mRr = 0; mActive = 0;
      mReqReady = '0; mRspValid = '0; mStart = 1'b0;
      mRspError = 8'h00; mTimeoutErr = 1'b0; mSysReady = 1'b0;
    end else begin
      nxt = mState;
      case (mState)
        0: begin
          if (!bus.bridge_busy && (bus.req_valid != '0)) begin
            found = 1'b0;
            for (int k = 0; k < NumReq; k++) begin
              idx = (mRr + k) % NumReq;
              rot = bus.req_valid >> idx;
              if (!found && rot[0]) begin
                found  = 1'b1;
                mGrant = idx;
              end
            end
            nxt = 1;
          end
        end
        1: begin
          mActive = 0;
          nxt = 2;
        end
        2: begin
          mActive++;
          if (bus.bridge_done) begin
            mRspError = bus.bridge_error;
            nxt = 3;
          end else if (mActive == TimeoutCycles) begin
            mRspError   = ErrTimeout;
            mTimeoutErr = 1'b1;
            nxt = 3;
          end
        end
        3: begin
          mRr = (mGrant + 1) % NumReq;
          nxt = bus.bridge_busy ? 4 : 0;
        end
        default: nxt = bus.bridge_busy ? 4 : 0;
      endcase
      mReqReady = (nxt == 1) ? (ReqOne << mGrant) : '0;
      mStart    = (nxt == 1);
      mRspValid = (nxt == 3) ? (ReqOne << mGrant) : '0;
      mSysReady = (nxt == 0) && !bus.bridge_busy;
      mState    = nxt;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    checkOutput("arb_state",    32'(bus.arb_state),    32'(mState));
    checkOutput("grant_id",     32'(bus.grant_id),     32'(mGrant));
    checkOutput("req_ready",    32'(bus.req_ready),    32'(mReqReady));
    checkOutput("bridge_start", 32'(bus.bridge_start), 32'(mStart));
    checkOutput("rsp_valid",    32'(bus.rsp_valid),    32'(mRspValid));
    checkOutput("rsp_error",    32'(bus.rsp_error),    32'(mRspError));
    checkOutput("timeout_err",  32'(bus.timeout_err),  32'(mTimeoutErr));
    checkOutput("system_ready", 32'(bus.system_ready), 32'(mSysReady));
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [NumReq-1:0] rv, input logic busy,
                               input logic done, input logic [7:0] err);
    bus.req_valid    = rv;
    bus.bridge_busy  = busy;
    bus.bridge_done  = done;
    bus.bridge_error = err;
    @(posedge clk);
    #1;
  endtask

  int                activeCount;
  int                guard;
  int                cnt;
  int                gq[$];
  int                expSeq[4] = '{0, 1, 0, 1};
  int                bLeft, bTail, idleBusy;
  logic              bHasDone;
  logic [NumReq-1:0] pend;

  initial begin
    bus.req_valid = '0; bus.bridge_busy = 1'b0; bus.bridge_done = 1'b0; bus.bridge_error = 8'h00;

    // Reset state
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_state", 32'(bus.arb_state), 32'd0);
    checkOutput("rst_outputs", 32'({bus.req_ready, bus.bridge_start, bus.rsp_valid,
                bus.rsp_error, bus.timeout_err, bus.system_ready, bus.grant_id}), 32'd0);
    rst_n = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_ready", 32'(bus.system_ready), 32'd1);

    // Single request, done in the 5th ACTIVE cycle
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_req_ready", 32'(bus.req_ready), 32'b001);
    checkOutput("t1_start", 32'(bus.bridge_start), 32'd1);
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    checkOutput("t1_active", 32'(bus.arb_state), 32'd2);
    repeat (4) applyStimulus('0, 1'b1, 1'b0, 8'h00);
    applyStimulus('0, 1'b0, 1'b1, 8'h00);
    checkOutput("t1_rsp_valid", 32'(bus.rsp_valid), 32'b001);
    checkOutput("t1_rsp_error", 32'(bus.rsp_error), 32'h00);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_back_idle", 32'(bus.arb_state), 32'd0);

    // Fairness from a fresh round-robin pointer
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    cnt = 0; guard = 0;
    while (gq.size() < 4 && guard < 100) begin
      applyStimulus(3'b011, cnt > 1, cnt == 1, 8'h00);
      if (cnt > 0) cnt--;
      if (bus.bridge_start) begin
        gq.push_back(int'(bus.grant_id));
        cnt = 3;
      end
      guard++;
    end
    checkOutput("t2_grant_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_grant_seq", (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(expSeq[i]));
    end
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    applyStimulus('0, 1'b0, 1'b1, 8'h00);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);

    // Timeout, then drain with the bridge still busy
    applyStimulus(3'b010, 1'b0, 1'b0, 8'h00);
    checkOutput("t3_grant", 32'(bus.grant_id), 32'd1);
    activeCount = 0; guard = 0;
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    while (bus.arb_state == 3'd2 && guard < 100) begin
      activeCount++;
      guard++;
      applyStimulus('0, 1'b1, 1'b0, 8'h00);
    end
    checkOutput("t3_active_cycles", 32'(activeCount), 32'd16);
    checkOutput("t3_rsp_valid", 32'(bus.rsp_valid), 32'b010);
    checkOutput("t3_rsp_error", 32'(bus.rsp_error), 32'hE0);
    checkOutput("t3_timeout_err", 32'(bus.timeout_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b001, 1'b1, 1'b0, 8'h00);
      checkOutput("t3_drain_state", 32'(bus.arb_state), 32'd4);
      checkOutput("t3_drain_no_grant", 32'(bus.req_ready), 32'd0);
    end
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    checkOutput("t3_drain_exit", 32'(bus.arb_state), 32'd0);
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    checkOutput("t3_regrant", 32'(bus.req_ready), 32'b001);
    checkOutput("t3_sticky", 32'(bus.timeout_err), 32'd1);
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    applyStimulus('0, 1'b0, 1'b1, 8'h00);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);

    // Bridge error code passes through to the owner only
    applyStimulus(3'b100, 1'b0, 1'b0, 8'h00);
    checkOutput("t4_grant", 32'(bus.grant_id), 32'd2);
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    applyStimulus('0, 1'b1, 1'b1, 8'h03);
    checkOutput("t4_rsp_valid", 32'(bus.rsp_valid), 32'b100);
    checkOutput("t4_rsp_error", 32'(bus.rsp_error), 32'h03);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    checkOutput("t4_error_hold", 32'(bus.rsp_error), 32'h03);

    // Done in the same cycle the watchdog expires
    rst_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    applyStimulus(3'b001, 1'b0, 1'b0, 8'h00);
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    repeat (15) applyStimulus('0, 1'b1, 1'b0, 8'h00);
    applyStimulus('0, 1'b1, 1'b1, 8'h5A);
    checkOutput("t5_state", 32'(bus.arb_state), 32'd3);
    checkOutput("t5_rsp_error", 32'(bus.rsp_error), 32'h5A);
    checkOutput("t5_timeout_err", 32'(bus.timeout_err), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);

    // Reset while ACTIVE aborts silently
    applyStimulus(3'b010, 1'b0, 1'b0, 8'h00);
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    applyStimulus('0, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b0;
    applyStimulus('0, 1'b1, 1'b1, 8'h77);
    rst_n = 1'b1;
    checkOutput("t6_state", 32'(bus.arb_state), 32'd0);
    checkOutput("t6_outputs", 32'({bus.req_ready, bus.bridge_start, bus.rsp_valid,
                bus.rsp_error, bus.timeout_err, bus.system_ready, bus.grant_id}), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    checkOutput("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    applyStimulus('0, 1'b0, 1'b0, 8'h00);
    checkOutput("t6_ready", 32'(bus.system_ready), 32'd1);

    // Randomized traffic: random requesters, a bridge with varied latency, tails and stray pulses
    pend = '0; bLeft = 0; bTail = 0; idleBusy = 0; bHasDone = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (bus.bridge_start) begin
        bLeft    = $urandom_range(2, 22);
        bHasDone = ($urandom_range(0, 3) != 0);
        bTail    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      end
      pend  = (pend & ~bus.req_ready) | (NumReq'($urandom) & NumReq'($urandom));
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus(pend,
                    (bLeft > 0) || (bTail > 0) || (idleBusy > 0),
                    ((bLeft == 1) && bHasDone) || ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      if (bLeft > 0) bLeft--;
      else if (bTail > 0) bTail--;
      if (idleBusy > 0) idleBusy--;
      else if ($urandom_range(0, 39) == 0) idleBusy = $urandom_range(1, 4);
    end
    rst_n = 1'b1;
    repeat (3) applyStimulus('0, 1'b0, 1'b0, 8'h00);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
